// File: rtl/weight_preload_fifo.sv
// AXI4-Stream weight packer and word FIFO feeding the weight BRAM controller.
// Define WPRELOAD_UNDERFLOW_FLAG_EN to add the sticky fifo_err output.
module weight_preload_fifo #(
  parameter int unsigned  MAC_NUM         = 256,
  parameter int unsigned  AXIS_DATA_WIDTH = 64,
  parameter int unsigned  FIFO_DEPTH      = 4,
  localparam int unsigned WW              = 5 * MAC_NUM,
  localparam int unsigned CNT_W           = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic [AXIS_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                       s_axis_tvalid,
  input  logic                       s_axis_tlast,
  output logic                       s_axis_tready,
  output logic [WW-1:0]              weight_from_preload,
  output logic [CNT_W-1:0]           axis_fifo_cnt,
  output logic                       wait_weight_preload,
`ifdef WPRELOAD_UNDERFLOW_FLAG_EN
  output logic                       fifo_err,
`endif
  input  logic                       axis_fifo_read
);

  localparam int unsigned BEATS = WW / AXIS_DATA_WIDTH;
  localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned PW    = $clog2(FIFO_DEPTH);

  localparam logic [BW-1:0]    LastBeat = BW'(BEATS - 1);
  localparam logic [CNT_W-1:0] Full     = CNT_W'(FIFO_DEPTH);

  if (WW % AXIS_DATA_WIDTH != 0) begin : g_bad_width
    $error("5*MAC_NUM must be a multiple of AXIS_DATA_WIDTH");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two >= 2");
  end

  typedef enum logic [0:0] {StFill, StLast} state_e;

  // A single-beat word means every accepted beat is the last one.
  localparam state_e StInit = (BEATS == 1) ? StLast : StFill;

  state_e            state_q, state_d;
  logic [BW-1:0]     beat_cnt_q, beat_cnt_d;
  logic [WW-1:0]     pack_q, pack_d, word_comb;
  logic [WW-1:0]     mem_q [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              is_last, push_cond, accept, push, pop;

  // Packer FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StInit;
    else        state_q <= state_d;
  end

  // Packer FSM: next state
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = StInit;
    end else if (accept) begin
      state_d = (beat_cnt_d == LastBeat) ? StLast : StFill;
    end
  end

  // Packer FSM: outputs
  always_comb begin
    is_last = (state_q == StLast);
  end

  assign push_cond     = is_last | s_axis_tlast;
  // Back-pressure only the pushing beat; a flush drops whatever is presented.
  assign s_axis_tready = flush | ~(s_axis_tvalid & push_cond & (cnt_q == Full));
  assign accept        = s_axis_tvalid & s_axis_tready;
  assign push          = accept & push_cond & ~flush;
  assign pop           = axis_fifo_read & (cnt_q != '0) & ~flush;

  // Current beat merged into the partial word so the push needs no extra cycle.
  always_comb begin
    word_comb = pack_q;
    for (int unsigned k = 0; k < BEATS; k++) begin
      if (beat_cnt_q == BW'(k)) begin
        word_comb[k*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH] = s_axis_tdata;
      end
    end
  end

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    pack_d     = pack_q;
    if (flush || (accept && push_cond)) begin
      beat_cnt_d = '0;
      pack_d     = '0;
    end else if (accept) begin
      beat_cnt_d = beat_cnt_q + BW'(1);
      pack_d     = word_comb;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (flush) begin
      cnt_d = '0;
    end else begin
      unique case ({push, pop})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt_q <= '0;
      pack_q     <= '0;
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
      pack_q     <= pack_d;
      cnt_q      <= cnt_d;
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= word_comb;
    end
  end

  assign weight_from_preload = mem_q[rd_ptr_q];
  assign axis_fifo_cnt       = cnt_q;
  assign wait_weight_preload = (cnt_q != '0);

`ifdef WPRELOAD_UNDERFLOW_FLAG_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (flush) begin
      err_d = 1'b0;
    end else if ((axis_fifo_read && cnt_q == '0) || (accept && s_axis_tlast && !is_last)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign fifo_err = err_q;
`endif

endmodule

// File: tb/tb_weight_preload_fifo.sv
// Directed bench for weight_preload_fifo at default parameters (20 beats of 64 bits per word).
module tb_weight_preload_fifo;

  localparam int WW  = 1280;
  localparam int ADW = 64;
  localparam int NB  = 20;

  logic            clk;
  logic            rst_n;
  logic            flush;
  logic [ADW-1:0]  s_axis_tdata;
  logic            s_axis_tvalid;
  logic            s_axis_tlast;
  logic            s_axis_tready;
  logic [WW-1:0]   weight_from_preload;
  logic [2:0]      axis_fifo_cnt;
  logic            wait_weight_preload;
  logic            axis_fifo_read;
`ifdef WPRELOAD_UNDERFLOW_FLAG_EN
  logic            fifo_err;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  weight_preload_fifo #(
    .MAC_NUM         (256),
    .AXIS_DATA_WIDTH (64),
    .FIFO_DEPTH      (4)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .flush               (flush),
    .s_axis_tdata        (s_axis_tdata),
    .s_axis_tvalid       (s_axis_tvalid),
    .s_axis_tlast        (s_axis_tlast),
    .s_axis_tready       (s_axis_tready),
    .weight_from_preload (weight_from_preload),
    .axis_fifo_cnt       (axis_fifo_cnt),
    .wait_weight_preload (wait_weight_preload),
`ifdef WPRELOAD_UNDERFLOW_FLAG_EN
    .fifo_err            (fifo_err),
`endif
    .axis_fifo_read      (axis_fifo_read)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Head word: beats below n hold base+k, the rest must be zero.
  task automatic check_word(input string tag, input logic [63:0] base, input int n);
    for (int k = 0; k < NB; k++) begin
      check($sformatf("%s_b%0d", tag, k), weight_from_preload[k*ADW +: ADW],
            (k < n) ? base + 64'(k) : 64'd0);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beats(input logic [63:0] base, input int n, input logic last);
    for (int k = 0; k < n; k++) begin
      s_axis_tdata  = base + 64'(k);
      s_axis_tvalid = 1'b1;
      s_axis_tlast  = last && (k == n - 1);
      tick();
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic pop();
    axis_fifo_read = 1'b1;
    tick();
    axis_fifo_read = 1'b0;
  endtask

  initial begin
    rst_n          = 1'b0;
    flush          = 1'b0;
    s_axis_tdata   = '0;
    s_axis_tvalid  = 1'b0;
    s_axis_tlast   = 1'b0;
    axis_fifo_read = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_cnt", 64'(axis_fifo_cnt), 64'd0);
    check("rst_wait", 64'(wait_weight_preload), 64'd0);
    check("rst_tready", 64'(s_axis_tready), 64'd1);
    check("rst_head", weight_from_preload[63:0], 64'd0);
`ifdef WPRELOAD_UNDERFLOW_FLAG_EN
    check("rst_err", 64'(fifo_err), 64'd0);
`endif
    rst_n = 1'b1;
    tick();

    // 1: one full word, data = beat index
    send_beats(64'd0, 19, 1'b0);
    check("t1_cnt_before", 64'(axis_fifo_cnt), 64'd0);
    send_beats(64'd19, 1, 1'b1);
    check("t1_cnt", 64'(axis_fifo_cnt), 64'd1);
    check("t1_wait", 64'(wait_weight_preload), 64'd1);
    check_word("t1_word", 64'd0, NB);
    pop();
    check("t1_cnt_pop", 64'(axis_fifo_cnt), 64'd0);

    // 2: fill to 4, fifth word's last beat stalls until a pop
    send_beats(64'd100, NB, 1'b1);
    send_beats(64'd200, NB, 1'b1);
    send_beats(64'd300, NB, 1'b1);
    send_beats(64'd400, NB, 1'b1);
    check("t2_cnt_full", 64'(axis_fifo_cnt), 64'd4);
    send_beats(64'd500, 19, 1'b0);
    check("t2_cnt_19", 64'(axis_fifo_cnt), 64'd4);
    s_axis_tdata  = 64'd519;
    s_axis_tvalid = 1'b1;
    s_axis_tlast  = 1'b1;
    #1;
    check("t2_tready_full", 64'(s_axis_tready), 64'd0);
    check_word("t2_head", 64'd100, NB);
    axis_fifo_read = 1'b1;
    tick();
    axis_fifo_read = 1'b0;
    #1;
    check("t2_cnt_popped", 64'(axis_fifo_cnt), 64'd3);
    check("t2_tready_free", 64'(s_axis_tready), 64'd1);
    tick();
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    check("t2_cnt_refill", 64'(axis_fifo_cnt), 64'd4);
    check_word("t2_head2", 64'd200, NB);

    // 3: simultaneous push and pop at cnt=2
    pop();
    pop();
    check("t3_cnt2", 64'(axis_fifo_cnt), 64'd2);
    check_word("t3_head400", 64'd400, NB);
    send_beats(64'd600, 19, 1'b0);
    s_axis_tdata   = 64'd619;
    s_axis_tvalid  = 1'b1;
    s_axis_tlast   = 1'b1;
    axis_fifo_read = 1'b1;
    tick();
    s_axis_tvalid  = 1'b0;
    s_axis_tlast   = 1'b0;
    axis_fifo_read = 1'b0;
    check("t3_cnt_same", 64'(axis_fifo_cnt), 64'd2);
    check_word("t3_head500", 64'd500, NB);
    pop();
    check_word("t3_head600", 64'd600, NB);
    pop();
    check("t3_cnt_empty", 64'(axis_fifo_cnt), 64'd0);
    check("t3_wait_empty", 64'(wait_weight_preload), 64'd0);

    // 4: early tlast pads with zeros, next word restarts at beat 0
    send_beats(64'd700, 7, 1'b1);
    check("t4_cnt", 64'(axis_fifo_cnt), 64'd1);
    check_word("t4_short", 64'd700, 7);
`ifdef WPRELOAD_UNDERFLOW_FLAG_EN
    check("t4_err_early_last", 64'(fifo_err), 64'd1);
`endif
    send_beats(64'd800, NB, 1'b1);
    check("t4_cnt2", 64'(axis_fifo_cnt), 64'd2);
    pop();
    check_word("t4_next", 64'd800, NB);
    pop();

    // 5: flush with three words stored and a partial word in the packer
    send_beats(64'd900, NB, 1'b1);
    send_beats(64'd1000, NB, 1'b1);
    send_beats(64'd1100, NB, 1'b1);
    check("t5_cnt3", 64'(axis_fifo_cnt), 64'd3);
    send_beats(64'd1200, 10, 1'b0);
    flush         = 1'b1;
    s_axis_tdata  = 64'hdead;
    s_axis_tvalid = 1'b1;
    s_axis_tlast  = 1'b1;
    #1;
    check("t5_tready_flush", 64'(s_axis_tready), 64'd1);
    tick();
    flush         = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    check("t5_cnt_flushed", 64'(axis_fifo_cnt), 64'd0);
    check("t5_wait_flushed", 64'(wait_weight_preload), 64'd0);
`ifdef WPRELOAD_UNDERFLOW_FLAG_EN
    check("t5_err_cleared", 64'(fifo_err), 64'd0);
`endif
    send_beats(64'd1300, 19, 1'b0);
    check("t5_cnt_19", 64'(axis_fifo_cnt), 64'd0);
    send_beats(64'd1319, 1, 1'b1);
    check("t5_cnt_fresh", 64'(axis_fifo_cnt), 64'd1);
    check_word("t5_fresh", 64'd1300, NB);

    // 6: pop on empty is ignored
    pop();
    check("t6_cnt0", 64'(axis_fifo_cnt), 64'd0);
`ifdef WPRELOAD_UNDERFLOW_FLAG_EN
    check("t6_err_before", 64'(fifo_err), 64'd0);
`endif
    pop();
    check("t6_cnt_still0", 64'(axis_fifo_cnt), 64'd0);
    check("t6_wait", 64'(wait_weight_preload), 64'd0);
    send_beats(64'd1400, NB, 1'b1);
    check("t6_cnt1", 64'(axis_fifo_cnt), 64'd1);
    check_word("t6_head", 64'd1400, NB);
`ifdef WPRELOAD_UNDERFLOW_FLAG_EN
    check("t6_err_set", 64'(fifo_err), 64'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("t6_err_flush", 64'(fifo_err), 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
